// File: rtl/display_ctrl.sv
// Numeric display and feedback unit: double-dabble BCD conversion, multiplexed
// 7-segment scanning with blanking/sign/error glyphs, and a retriggerable monostable.
module display_ctrl #(
   parameter int DIGITS   = 4,
   parameter int DATA_W   = 16,
   parameter int SCAN_DIV = 50000,
   parameter int ACK_LEN  = 250000,
   parameter int ERR_LEN  = 25000000
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        cmd,
   output logic              busy,
   output logic [DIGITS-1:0] SD,
   output logic [7:0]        SEG,
   output logic [7:0]        LD,
   output logic              Buzz
);

   localparam int IW     = $clog2(DIGITS);
   localparam int BW     = 4 * DIGITS;
   localparam int STW    = $clog2(DATA_W + 1);
   localparam int SW     = $clog2(SCAN_DIV + 1);
   localparam int MAXLEN = (ERR_LEN > ACK_LEN) ? ERR_LEN : ACK_LEN;
   localparam int MW     = $clog2(MAXLEN + 1);
   localparam longint MAXV = longint'(10) ** DIGITS - 1;
   localparam longint MINV = -(longint'(10) ** (DIGITS - 1) - 1);

   localparam logic [7:0] GLYPH_E     = 8'b01100001;
   localparam logic [7:0] GLYPH_MINUS = 8'b11111101;
   localparam logic [7:0] GLYPH_BLANK = 8'hFF;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_NUM, CMD_ACK, CMD_ERR} cmd_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] mag, mag_n, mag_in;
   logic              sign_r, sign_n;
   logic [BW-1:0]     bcd, bcd_n, bcd_adj;
   logic [STW-1:0]    step, step_n;
   logic [BW-1:0]     disp_bcd, disp_bcd_n;
   logic              disp_neg, disp_neg_n;
   logic              err, err_n;
   logic [MW-1:0]     mono_cnt, mono_n;
   logic [SW-1:0]     scan_cnt;
   logic [IW-1:0]     scan_idx;
   logic [IW-1:0]     ms;
   logic [7:0]        glyph [DIGITS];
   logic [DIGITS-1:0] sd_n;
   logic signed [63:0] data_ext;
   logic              in_range;

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 8'b00000011;
         4'd1:    seg7 = 8'b10011111;
         4'd2:    seg7 = 8'b00100101;
         4'd3:    seg7 = 8'b00001101;
         4'd4:    seg7 = 8'b10011001;
         4'd5:    seg7 = 8'b01001001;
         4'd6:    seg7 = 8'b01000001;
         4'd7:    seg7 = 8'b00011111;
         4'd8:    seg7 = 8'b00000001;
         4'd9:    seg7 = 8'b00001001;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   assign data_ext = {{(64-DATA_W){data[DATA_W-1]}}, data};
   assign in_range = (data_ext >= MINV) && (data_ext <= MAXV);
   assign mag_in   = data[DATA_W-1] ? (~data + DATA_W'(1)) : data;

   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         mag      <= '0;
         sign_r   <= 1'b0;
         bcd      <= '0;
         step     <= '0;
         disp_bcd <= '0;
         disp_neg <= 1'b0;
         err      <= 1'b0;
         mono_cnt <= '0;
      end else begin
         state    <= state_n;
         mag      <= mag_n;
         sign_r   <= sign_n;
         bcd      <= bcd_n;
         step     <= step_n;
         disp_bcd <= disp_bcd_n;
         disp_neg <= disp_neg_n;
         err      <= err_n;
         mono_cnt <= mono_n;
      end
   end

   // Commit is suppressed whenever a NUM lands on it, valid or not.
   always_comb begin
      state_n    = state;
      mag_n      = mag;
      sign_n     = sign_r;
      bcd_n      = bcd;
      step_n     = step;
      disp_bcd_n = disp_bcd;
      disp_neg_n = disp_neg;
      err_n      = err;
      mono_n     = (mono_cnt != '0) ? mono_cnt - MW'(1) : mono_cnt;

      case (state)
         CONV: begin
            bcd_n  = {bcd_adj[BW-2:0], mag[DATA_W-1]};
            mag_n  = mag << 1;
            step_n = step + STW'(1);
            if (step == STW'(DATA_W - 1)) state_n = COMMIT;
         end
         COMMIT: begin
            if (cmd != CMD_NUM) begin
               disp_bcd_n = bcd;
               disp_neg_n = sign_r;
               err_n      = 1'b0;
               state_n    = IDLE;
            end
         end
         default: ;
      endcase

      case (cmd)
         CMD_NUM: begin
            if (in_range) begin
               state_n = CONV;
               mag_n   = mag_in;
               sign_n  = data[DATA_W-1];
               bcd_n   = '0;
               step_n  = '0;
            end else begin
               state_n = IDLE;
               err_n   = 1'b1;
               mono_n  = MW'(ERR_LEN);
            end
         end
         CMD_ACK: begin
            err_n  = 1'b0;
            mono_n = MW'(ACK_LEN);
         end
         CMD_ERR: begin
            err_n  = 1'b1;
            mono_n = MW'(ERR_LEN);
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);
   assign LD   = {8{mono_cnt != '0}};
   assign Buzz = (mono_cnt == '0);

   always_comb begin
      ms = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (disp_bcd[4*i +: 4] != 4'd0) ms = IW'(i);
      end
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (err)
            glyph[i] = GLYPH_E;
         else if (IW'(i) <= ms)
            glyph[i] = seg7(disp_bcd[4*i +: 4]);
         else if (disp_neg && ((IW+1)'(i) == ({1'b0, ms} + (IW+1)'(1))))
            glyph[i] = GLYPH_MINUS;
         else
            glyph[i] = GLYPH_BLANK;
      end
      sd_n           = '1;
      sd_n[scan_idx] = 1'b0;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         SD       <= '1;
         SEG      <= 8'hFF;
         scan_cnt <= '0;
         scan_idx <= IW'(DIGITS - 1);
      end else begin
         SD  <= sd_n;
         SEG <= glyph[scan_idx];
         if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == '0) ? IW'(DIGITS - 1) : scan_idx - IW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_display_ctrl.sv
// Bench for display_ctrl: directed scenarios plus random commands, every cycle
// compared against an integer-arithmetic model of the display and pulse timing.
module tb_display_ctrl;

   localparam int DIGITS   = 4;
   localparam int DATA_W   = 16;
   localparam int SCAN_DIV = 4;
   localparam int ACK_LEN  = 5;
   localparam int ERR_LEN  = 20;

   logic              Clock, Reset;
   logic [DATA_W-1:0] data;
   logic [1:0]        cmd;
   logic              busy;
   logic [DIGITS-1:0] SD;
   logic [7:0]        SEG, LD;
   logic              Buzz;

   int errors = 0;
   int checks = 0;

   longint edge_n, commit_at, mono_until;
   int     disp_val, pend_val;
   bit     err_m, pend;

   display_ctrl #(
      .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV),
      .ACK_LEN(ACK_LEN), .ERR_LEN(ERR_LEN)
   ) dut (
      .Clock(Clock), .Reset(Reset), .data(data), .cmd(cmd), .busy(busy),
      .SD(SD), .SEG(SEG), .LD(LD), .Buzz(Buzz)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] num_glyph(input int d);
      case (d)
         0: return 8'b00000011;
         1: return 8'b10011111;
         2: return 8'b00100101;
         3: return 8'b00001101;
         4: return 8'b10011001;
         5: return 8'b01001001;
         6: return 8'b01000001;
         7: return 8'b00011111;
         8: return 8'b00000001;
         9: return 8'b00001001;
         default: return 8'hFF;
      endcase
   endfunction

   // Glyph for digit i (0 = units) of the displayed decimal value.
   function automatic logic [7:0] exp_glyph(input int i);
      int a, nd, t, p;
      if (err_m) return 8'b01100001;
      a  = (disp_val < 0) ? -disp_val : disp_val;
      nd = 1;
      t  = a;
      while (t >= 10) begin
         t = t / 10;
         nd++;
      end
      if (i < nd) begin
         p = 1;
         for (int k = 0; k < i; k++) p = p * 10;
         return num_glyph((a / p) % 10);
      end
      if (disp_val < 0 && i == nd) return 8'b11111101;
      return 8'hFF;
   endfunction

   task automatic model_reset();
      edge_n     = 0;
      commit_at  = 0;
      mono_until = 0;
      disp_val   = 0;
      pend_val   = 0;
      err_m      = 1'b0;
      pend       = 1'b0;
   endtask

   task automatic check_reset();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sd",   32'(SD),   32'hF);
      check("rst_seg",  32'(SEG),  32'hFF);
      check("rst_ld",   32'(LD),   32'h00);
      check("rst_buzz", 32'(Buzz), 32'd1);
   endtask

   // Called at a falling edge; drives one command for one clock and checks all outputs.
   task automatic tick(input logic [1:0] c, input int v);
      logic [DIGITS-1:0] exp_sd;
      logic [7:0]        exp_seg;
      int                dig, sv, lo, hi;
      bit                mono;
      longint            j;
      cmd  = c;
      data = v[DATA_W-1:0];
      @(posedge Clock);
      j      = edge_n + 1;
      edge_n = j;
      dig    = DIGITS - 1 - int'(((j - 1) / SCAN_DIV) % DIGITS);
      exp_sd = '1;
      exp_sd[dig] = 1'b0;
      exp_seg = exp_glyph(dig);

      sv = int'($signed(data));
      hi = 1;
      for (int k = 0; k < DIGITS; k++) hi = hi * 10;
      lo = -(hi / 10 - 1);
      hi = hi - 1;
      if (c == 2'd1) begin
         if (sv >= lo && sv <= hi) begin
            pend      = 1'b1;
            pend_val  = sv;
            commit_at = j + DATA_W + 1;
         end else begin
            pend       = 1'b0;
            err_m      = 1'b1;
            mono_until = j + ERR_LEN - 1;
         end
      end else begin
         if (pend && j == commit_at) begin
            disp_val = pend_val;
            err_m    = 1'b0;
            pend     = 1'b0;
         end
         if (c == 2'd2) begin
            err_m      = 1'b0;
            mono_until = j + ACK_LEN - 1;
         end else if (c == 2'd3) begin
            err_m      = 1'b1;
            mono_until = j + ERR_LEN - 1;
         end
      end
      mono = (j <= mono_until);

      #1;
      check("sd",   32'(SD),   32'(exp_sd));
      check("seg",  32'(SEG),  32'(exp_seg));
      check("busy", 32'(busy), 32'(pend));
      check("ld",   32'(LD),   mono ? 32'hFF : 32'h00);
      check("buzz", 32'(Buzz), 32'(!mono));
      @(negedge Clock);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cmd   = 2'd0;
      #1;
      check_reset();
      model_reset();
      @(negedge Clock);
      check_reset();
      Reset = 1'b0;
   endtask

   int r, v;

   initial begin
      Reset = 1'b1;
      cmd   = 2'd0;
      data  = '0;
      model_reset();
      repeat (2) @(negedge Clock);
      check_reset();
      Reset = 1'b0;

      repeat (16) tick(2'd0, 0);
      tick(2'd1, 1234);
      repeat (30) tick(2'd0, 0);
      tick(2'd1, -42);
      repeat (30) tick(2'd0, 0);
      tick(2'd1, 10000);
      repeat (3) tick(2'd0, 0);
      tick(2'd1, -1000);
      repeat (25) tick(2'd0, 0);
      tick(2'd3, 0);
      repeat (5) tick(2'd0, 0);
      tick(2'd2, 0);
      repeat (10) tick(2'd0, 0);
      tick(2'd1, 9999);
      repeat (20) tick(2'd0, 0);
      tick(2'd1, -999);
      repeat (20) tick(2'd0, 0);
      tick(2'd1, 5678);
      repeat (4) tick(2'd0, 0);
      tick(2'd1, 9);
      repeat (2) tick(2'd0, 0);
      do_reset();
      repeat (20) tick(2'd0, 0);

      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: v = int'($urandom_range(0, 10998)) - 999;
            5, 6: begin
               case ($urandom_range(0, 7))
                  0: v = 9999;
                  1: v = 10000;
                  2: v = -999;
                  3: v = -1000;
                  4: v = 0;
                  5: v = -1;
                  6: v = 32767;
                  default: v = -32768;
               endcase
            end
            default: v = int'($signed(16'($urandom())));
         endcase
         if (r < 4)      tick(2'd1, v);
         else if (r < 6) tick(2'd2, v);
         else if (r < 7) tick(2'd3, v);
         else            tick(2'd0, v);
      end
      repeat (40) tick(2'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Parametrised numeric display and feedback unit for the calculator. It takes two's-complement results and display commands from the core and converts the magnitude to BCD with a sequential double-dabble engine. It drives a DIGITS-wide multiplexed 7-segment display with leading-zero blanking, a minus sign and an error glyph, and drives a retriggerable monostable on the LEDs and buzzer. It sits between the core's output command port and the board pins.

## Interface
Parameters:
- DIGITS, 4: number of display digits (2..8).
- DATA_W, 16: width of `data`, two's complement. Must be ≥ bits needed for 10^DIGITS−1 plus sign.
- SCAN_DIV, 50000: clock cycles each digit is driven.
- ACK_LEN, 250000: monostable length for acknowledge, in cycles.
- ERR_LEN, 25000000: monostable length for error, in cycles.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- data  in  DATA_W  signed value. Sampled only when `cmd` = NUM.
- cmd  in  2  one-cycle command: 0 NONE, 1 NUM, 2 ACK, 3 ERR.
- busy  out  1  high while a conversion is in progress.
- SD  out  DIGITS  active-low digit select. Bit DIGITS−1 is the leftmost (most significant) digit.
- SEG  out  8  active-low segments {a,b,c,d,e,f,g,dp}, bit 7 = a.
- LD  out  8  all bits equal the monostable output.
- Buzz  out  1  inverse of the monostable output.

## Operation
- Range check is combinational on `data` when `cmd` = NUM. In range means −(10^(DIGITS−1)−1) ≤ data ≤ 10^DIGITS−1.
- NUM, in range:
  - Latch the sign and |data| and start the conversion FSM.
  - The err flag is not changed until the conversion completes.
- NUM, out of range:
  - Set err at the next edge.
  - Cancel any running conversion.
  - Trigger the monostable with ERR_LEN.
- ACK: clear err; trigger with ACK_LEN. The displayed digits are unchanged.
- ERR: set err; trigger with ERR_LEN. The displayed digits are unchanged.
- Conversion FSM states:
  - IDLE → CONV on a valid NUM.
  - CONV runs exactly DATA_W shift steps: add-3 to each BCD nibble ≥ 5, then shift in the next magnitude bit MSB-first. It then goes to COMMIT.
  - COMMIT copies the BCD and sign into the display registers, clears err, and returns to IDLE.
- A NUM arriving in CONV or COMMIT restarts the conversion with the new value (latest wins). A COMMIT that coincides with a new NUM is discarded.
- BCD working register is 4·DIGITS bits. In-range values never overflow it.
- Glyph selection, per digit, leftmost first:
  - err: every digit shows 'E' = 8'b01100001.
  - Digits left of the most-significant nonzero digit are blank (8'hFF). The units digit is always shown, so zero displays "0".
  - A negative value puts '−' = 8'b11111101 in the blank digit immediately left of the most-significant digit.
  - Numerals use the standard active-low patterns, dp off, e.g. 0 = 8'b00000011, 1 = 8'b10011111, 8 = 8'b00000001.
- Scanner:
  - A counter wraps every SCAN_DIV cycles. On wrap, the digit index advances leftmost → rightmost, then wraps back to the leftmost.
  - SD drives the active index low and all others high. SEG shows that digit's glyph.
  - SD and SEG are registered.
- Monostable:
  - A trigger loads the counter with the new length, even when the counter is already running and even if the new length is shorter.
  - Output = (counter ≠ 0). The counter decrements each cycle while nonzero.

## Timing
- Reset values:
  - busy = 0, SD = all 1s, SEG = 8'hFF, LD = 0, Buzz = 1.
  - FSM in IDLE, err = 0, displayed value +0, scan index at the leftmost digit, scan counter 0, monostable counter 0.
- After reset, the first registered scan output appears on the next edge.
- Conversion latency, with NUM sampled at edge t:
  - busy = 1 from t+1 through t+DATA_W+1.
  - New digits are visible in the glyph logic from t+DATA_W+2.
  - busy returns to 0 at t+DATA_W+2.
- Out-of-range NUM, ACK and ERR sampled at edge t:
  - err and the monostable update at t+1.
  - The monostable output is high for exactly LEN cycles, t+1 … t+LEN.
- The displayed glyph changes on SEG at the next scan register update, i.e. the next edge.
- Reset asserted mid-conversion or mid-pulse: everything returns to reset values immediately. No commit happens.

## Test plan
Bench parameters: DIGITS=4, DATA_W=16, SCAN_DIV=4, ACK_LEN=5, ERR_LEN=20.
- Reset then idle → scanning leftmost to rightmost shows blank, blank, blank, "0" (SEG 8'hFF ×3, then 8'b00000011). SD walks 0111 → 1011 → 1101 → 1110, with each digit held for 4 cycles.
- NUM 1234 → busy high for 17 cycles. Then the digits show 1, 2, 3, 4. LD stays 0.
- NUM −42 → the digits show blank, '−', 4, 2 (8'hFF, 8'b11111101, …).
- NUM 10000, then NUM −1000 → all digits show 'E' one cycle after each command. LD = 8'hFF and Buzz = 0 for exactly 20 cycles after the last trigger. busy stays 0.
- ACK during an ERR pulse → the pulse is shortened to 5 cycles from the ACK and err clears. The previous valid digits reappear.
- NUM 5678, then NUM 9 five cycles later, then Reset asserted 3 cycles after that → the display returns to "0" and busy = 0 immediately. Neither value is ever committed.
